// File: rtl/batch_sequencer_pkg.sv
// Shared widths and helpers for the batch filter front end and core.
// N mirrors the control-word width the filter coefficients were built for.
package batch_sequencer_pkg;
    localparam int N = 8;

    typedef logic [1:0] cycle_t;

    function automatic int calc_d(input int depth, input int dsr);
        return depth / dsr;
    endfunction

    function automatic int calc_cw(input int depth, input int dsr);
        return $clog2(depth / dsr);
    endfunction
endpackage

// File: rtl/batch_sequencer_ds_shifter.sv
// Shift register of the last DSR control words plus the sub-sample counter.
// done_o is combinational: high on the en clock that completes a group.
module batch_sequencer_ds_shifter
    import batch_sequencer_pkg::*;
#(
    parameter int DSR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_i,
    input  logic             en_i,
    output logic [N*DSR-1:0] shift_o,
    output logic             done_o
);
    logic [N*DSR-1:0] shift_q;

    generate
        if (DSR == 1) begin : g_nosub
            assign done_o = en_i;
            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_q <= '0;
                end else if (en_i) begin
                    shift_q <= in_i;
                end
            end
        end else begin : g_sub
            localparam int SW = $clog2(DSR);
            localparam logic [SW-1:0] SUB_MAX = SW'(DSR - 1);
            logic [SW-1:0] sub_q;

            assign done_o = en_i && (sub_q == SUB_MAX);
            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_q <= '0;
                    sub_q   <= '0;
                end else if (en_i) begin
                    // newest word enters at the bottom, oldest falls off the top
                    shift_q <= {shift_q[N*DSR-N-1:0], in_i};
                    sub_q   <= (sub_q == SUB_MAX) ? '0 : sub_q + 1'b1;
                end
            end
        end
    endgenerate

    assign shift_o = shift_q;
endmodule

// File: rtl/batch_sequencer.sv
// Packs DSR control words per vector and drives batch index / memory-section
// rotation for the batch filter core; flags when three full batches are stored.
module batch_sequencer
    import batch_sequencer_pkg::*;
#(
    parameter  int depth = 32,
    parameter  int DSR   = 1,
    localparam int D     = calc_d(depth, DSR),
    localparam int CW    = calc_cw(depth, DSR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic             en,
    output logic [N*DSR-1:0] inShift,
    output logic             sampleValid,
    output logic [CW-1:0]    dBatCount,
    output logic [CW-1:0]    dBatCountRev,
    output cycle_t           cycle,
    output cycle_t           cycleLH,
    output cycle_t           cycleCalc,
    output cycle_t           cycleIdle,
    output logic             cyclePulse,
    output logic             primed
);
    localparam logic [CW-1:0] CNT_MAX = CW'(D - 1);

    logic          done;
    logic          sample_valid_q, pulse_q, wrap;
    logic [CW-1:0] bat_cnt_q, bat_cnt_d, bat_rev_q;
    cycle_t        cyc_q, cyc_d, cyc_lh_q, cyc_calc_q, cyc_idle_q;
    logic [1:0]    nbat_q, nbat_d;
    logic          started_q, started_d, primed_q, primed_d;

    batch_sequencer_ds_shifter #(.DSR(DSR)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .in_i   (in),
        .en_i   (en),
        .shift_o(inShift),
        .done_o (done)
    );

    // The wrap out of the reset value D-1 is not a finished batch, so nBat
    // only starts counting once a first group has been seen.
    always_comb begin
        bat_cnt_d = bat_cnt_q;
        cyc_d     = cyc_q;
        nbat_d    = nbat_q;
        started_d = started_q;
        wrap      = 1'b0;
        if (done) begin
            started_d = 1'b1;
            if (bat_cnt_q == CNT_MAX) begin
                wrap      = 1'b1;
                bat_cnt_d = '0;
                cyc_d     = cyc_q + 2'd1;
                if (started_q && nbat_q != 2'd3) nbat_d = nbat_q + 2'd1;
            end else begin
                bat_cnt_d = bat_cnt_q + 1'b1;
            end
        end
        primed_d = primed_q | (nbat_d == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid_q <= 1'b0;
            pulse_q        <= 1'b0;
            bat_cnt_q      <= CNT_MAX;
            bat_rev_q      <= '0;
            cyc_q          <= 2'd3;
            cyc_lh_q       <= 2'd2;
            cyc_calc_q     <= 2'd1;
            cyc_idle_q     <= 2'd0;
            nbat_q         <= 2'd0;
            started_q      <= 1'b0;
            primed_q       <= 1'b0;
        end else begin
            sample_valid_q <= done;
            pulse_q        <= wrap;
            bat_cnt_q      <= bat_cnt_d;
            bat_rev_q      <= CNT_MAX - bat_cnt_d;
            cyc_q          <= cyc_d;
            cyc_lh_q       <= cyc_d - 2'd1;
            cyc_calc_q     <= cyc_d - 2'd2;
            cyc_idle_q     <= cyc_d - 2'd3;
            nbat_q         <= nbat_d;
            started_q      <= started_d;
            primed_q       <= primed_d;
        end
    end

    assign sampleValid  = sample_valid_q;
    assign cyclePulse   = pulse_q;
    assign dBatCount    = bat_cnt_q;
    assign dBatCountRev = bat_rev_q;
    assign cycle        = cyc_q;
    assign cycleLH      = cyc_lh_q;
    assign cycleCalc    = cyc_calc_q;
    assign cycleIdle    = cyc_idle_q;
    assign primed       = primed_q;
endmodule

// File: tb/tb_batch_sequencer.sv
// Three instances (DSR=4/D=8, DSR=1/D=32, DSR=4/D=6) share one stimulus stream;
// a per-instance model and an ideal-packer scoreboard check every clock.
module tb_batch_sequencer;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] din;
    int         k = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    logic [31:0] sh_a, sh_c;
    logic [7:0]  sh_b;
    logic [2:0]  cnt_a, rev_a, cnt_c, rev_c;
    logic [4:0]  cnt_b, rev_b;
    logic [1:0]  cyc [3], lh [3], calc [3], idle [3];
    logic        sv [3], pl [3], pr [3];
    logic [31:0] o_sh [3], o_cnt [3], o_rev [3];

    batch_sequencer #(.depth(32), .DSR(4)) u_a (
        .clk(clk), .rst(rst), .in(din), .en(en), .inShift(sh_a), .sampleValid(sv[0]),
        .dBatCount(cnt_a), .dBatCountRev(rev_a), .cycle(cyc[0]), .cycleLH(lh[0]),
        .cycleCalc(calc[0]), .cycleIdle(idle[0]), .cyclePulse(pl[0]), .primed(pr[0]));
    batch_sequencer #(.depth(32), .DSR(1)) u_b (
        .clk(clk), .rst(rst), .in(din), .en(en), .inShift(sh_b), .sampleValid(sv[1]),
        .dBatCount(cnt_b), .dBatCountRev(rev_b), .cycle(cyc[1]), .cycleLH(lh[1]),
        .cycleCalc(calc[1]), .cycleIdle(idle[1]), .cyclePulse(pl[1]), .primed(pr[1]));
    batch_sequencer #(.depth(24), .DSR(4)) u_c (
        .clk(clk), .rst(rst), .in(din), .en(en), .inShift(sh_c), .sampleValid(sv[2]),
        .dBatCount(cnt_c), .dBatCountRev(rev_c), .cycle(cyc[2]), .cycleLH(lh[2]),
        .cycleCalc(calc[2]), .cycleIdle(idle[2]), .cyclePulse(pl[2]), .primed(pr[2]));

    assign o_sh[0]  = sh_a;
    assign o_sh[1]  = {24'd0, sh_b};
    assign o_sh[2]  = sh_c;
    assign o_cnt[0] = {29'd0, cnt_a};
    assign o_cnt[1] = {27'd0, cnt_b};
    assign o_cnt[2] = {29'd0, cnt_c};
    assign o_rev[0] = {29'd0, rev_a};
    assign o_rev[1] = {27'd0, rev_b};
    assign o_rev[2] = {29'd0, rev_c};

    int dsrs [3] = '{4, 1, 4};
    int ds   [3] = '{8, 32, 6};
    int m_sub [3], m_cnt [3], m_cyc [3], m_nbat [3];
    int m_started [3], m_primed [3], m_sv [3], m_pl [3];
    logic [7:0]  grp [3][$];
    logic [31:0] sb  [3][$];

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: got %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        logic [31:0] v;
        @(negedge clk);
        rst = r;
        en  = e;
        din = 8'(k);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_sub[i] = 0; m_cnt[i] = ds[i] - 1; m_cyc[i] = 3; m_nbat[i] = 0;
                m_started[i] = 0; m_primed[i] = 0; m_sv[i] = 0; m_pl[i] = 0;
                grp[i].delete();
                sb[i].delete();
            end else if (e) begin
                grp[i].push_back(din);
                m_sv[i] = 0;
                m_pl[i] = 0;
                if (m_sub[i] == dsrs[i] - 1) begin
                    v = 0;
                    for (int j = 0; j < grp[i].size(); j++) v = (v << 8) | 32'(grp[i][j]);
                    grp[i].delete();
                    sb[i].push_back(v);
                    m_sub[i] = 0;
                    m_sv[i]  = 1;
                    if (m_cnt[i] == ds[i] - 1) begin
                        m_cnt[i] = 0;
                        m_cyc[i] = (m_cyc[i] + 1) % 4;
                        m_pl[i]  = 1;
                        if (m_started[i] != 0 && m_nbat[i] < 3) m_nbat[i]++;
                    end else begin
                        m_cnt[i]++;
                    end
                    m_started[i] = 1;
                    if (m_nbat[i] == 3) m_primed[i] = 1;
                end else begin
                    m_sub[i]++;
                end
            end else begin
                m_sv[i] = 0;
                m_pl[i] = 0;
            end
        end
        if (e && !r) k++;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sampleValid", i, 32'(sv[i]), 32'(m_sv[i]));
            chk("cyclePulse", i, 32'(pl[i]), 32'(m_pl[i]));
            chk("dBatCount", i, o_cnt[i], 32'(m_cnt[i]));
            chk("dBatCountRev", i, o_rev[i], 32'(ds[i] - 1 - m_cnt[i]));
            chk("cycle", i, 32'(cyc[i]), 32'(m_cyc[i]));
            chk("cycleLH", i, 32'(lh[i]), 32'((m_cyc[i] + 3) % 4));
            chk("cycleCalc", i, 32'(calc[i]), 32'((m_cyc[i] + 2) % 4));
            chk("cycleIdle", i, 32'(idle[i]), 32'((m_cyc[i] + 1) % 4));
            chk("primed", i, 32'(pr[i]), 32'(m_primed[i]));
            if (sv[i] === 1'b1) begin
                if (sb[i].size() == 0) chk("sb_underflow", i, 32'(sb[i].size()), 32'd1);
                else chk("inShift", i, o_sh[i], sb[i].pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = 8'd0;
        // reset state, then reset together with en (reset must win)
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        // continuous en: several batches, primed on the 4th pulse
        repeat (140) step(1'b0, 1'b1);
        // en toggling 1010...
        repeat (64) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        // reset after 2 words of a group
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b1);
        // random qualifier pattern
        repeat (200) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) chk("sb_leftover", i, 32'(sb[i].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/batch_sequencer.md
# batch_sequencer

Front-end stage of the batch floating-point filter. Takes the raw N-bit comparator control word each clock and packs DSR consecutive words into one down-sampled vector (`inShift`), raising a one-clock strobe per vector. Generates the batch index counters (`dBatCount`, `dBatCountRev`) and the 2-bit memory-section rotation (`cycle`, `cycleLH`, `cycleCalc`, `cycleIdle`, `cyclePulse`) that the batch filter core consumes directly. Also flags when enough batches have been stored for valid filter output.

## Interface
Parameters:
- `depth`, 32, batch length in full-rate samples
- `DSR`, 1, down-sample ratio; `depth` must be divisible by `DSR`
- Derived: `D = depth/DSR` (batch length in down-sampled samples, D ≥ 2); `CW = $clog2(D)`
- `N` is imported from `Coefficients` (not a parameter)

Ports:
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  synchronous, active-high reset
- `in`  in  N  control word, sampled when `en`=1
- `en`  in  1  input-valid qualifier
- `inShift`  out  N*DSR  last DSR words, newest in bits [N-1:0]
- `sampleValid`  out  1  one-clock strobe: new down-sampled vector on `inShift`
- `dBatCount`  out  CW  index of current vector within batch, 0..D-1
- `dBatCountRev`  out  CW  D-1-`dBatCount`
- `cycle`  out  2  memory section being written
- `cycleLH`  out  2  `cycle`-1 mod 4 (lookahead, read reversed)
- `cycleCalc`  out  2  `cycle`-2 mod 4 (calculation section)
- `cycleIdle`  out  2  `cycle`-3 mod 4
- `cyclePulse`  out  1  one-clock strobe on batch wrap
- `primed`  out  1  high once 3 complete batches are stored; sticky until reset

## Operation
- Sub-sample counter `subCnt` 0..DSR-1 (omitted when DSR=1). On each clock with `en`=1: shift `in` into `inShift` (old contents move up N bits, top word drops); if `subCnt`==DSR-1 the group completes, else `subCnt`++.
- On group completion: `sampleValid`=1 next clock; `dBatCount` increments, wrapping D-1 → 0.
- On wrap to 0: `cycle`++ mod 4, `cyclePulse`=1 for that same clock; batch counter `nBat` (saturating at 3) increments; `primed` sets when `nBat` reaches 3.
- `cycleLH`/`cycleCalc`/`cycleIdle` are registered and updated in the same clock as `cycle`.
- `en`=0: all state holds, strobes low.
- `inShift` shifts on every `en`, but is only meaningful to consumers when `sampleValid`=1.

## Timing
- All outputs registered. Latency: `en` edge completing a group → `inShift`, `sampleValid`, `dBatCount`, `dBatCountRev` updated at that same edge (visible the following clock).
- Reset values: `inShift`=0, `subCnt`=0, `sampleValid`=0, `dBatCount`=D-1, `dBatCountRev`=0, `cycle`=3, `cycleLH`=2, `cycleCalc`=1, `cycleIdle`=0, `cyclePulse`=0, `nBat`=0, `primed`=0. The first completed group after reset therefore shows `dBatCount`=0, `cycle`=0, `cyclePulse`=1.
- `cyclePulse` and `sampleValid` are coincident on the first vector of each batch; `cyclePulse` is never high without `sampleValid`.
- Reset mid-group: partial group discarded, sequence restarts exactly as from power-up.
- Reset asserted together with `en`: reset wins; no shift.
- Non-power-of-two D: `dBatCount` never exceeds D-1.

## Structure
- Add `D`/`CW` helper functions and a `cycle_t` (logic [1:0]) typedef to `Coefficients`, or to a small shared `BatchPkg`, so the core and this block agree on widths.
- Natural sub-module: `ds_shifter` (shift register plus `subCnt`, emitting a completion pulse). The batch/cycle counters stay in the top module.

## Test plan
- depth=32, DSR=1, `en`=1 continuously, `in`=k mod 2^N at clock k → `sampleValid` every clock; `inShift`=k; `dBatCount` 0..31 repeating; `cyclePulse` at k=0, 32, 64; `cycle` reads 0,1,2,3,0.
- depth=32, DSR=4 (D=8), `en`=1 → `sampleValid` every 4th clock; `inShift`={w0,w1,w2,w3} with w3 in the LSBs; `dBatCountRev`=7-`dBatCount`; `cyclePulse` every 32 clocks.
- DSR=4, `en` toggled 1010… → strobes every 8 clocks; no word lost or duplicated (scoreboard compares against an ideal packer).
- `primed` stays 0 through the end of batch 3, then goes 1 on the clock of the 4th `cyclePulse` (nBat reaching 3), and stays 1.
- `rst` pulsed after 2 of 4 words in a group → next strobe contains only post-reset words; `dBatCount`=0; `cycle`=0; `primed`=0.
- Every clock, check: `cycleLH`=`cycle`-1, `cycleCalc`=`cycle`-2, `cycleIdle`=`cycle`-3 mod 4; `cyclePulse` implies `sampleValid` and `dBatCount`=0.
